// File: rtl/req_pending_if.sv
// Bundles the request/acknowledge/overflow signals between the request capture
// stage and its consumer (priority encoder plus debug logic).
interface req_pending_if #(
  parameter int N_REQ = 16,
  parameter int CNT_W = 8
);
  logic             ena;
  logic [N_REQ-1:0] req_in;
  logic [N_REQ-1:0] mask;
  logic             ack_valid;
  logic [3:0]       ack_idx;
  logic             ovf_clr;
  logic [N_REQ-1:0] pending_out;
  logic             any_pending;
  logic             ovf_flag;
  logic [CNT_W-1:0] ovf_cnt;

  modport master (
    output ena, req_in, mask, ack_valid, ack_idx, ovf_clr,
    input  pending_out, any_pending, ovf_flag, ovf_cnt
  );

  modport slave (
    input  ena, req_in, mask, ack_valid, ack_idx, ovf_clr,
    output pending_out, any_pending, ovf_flag, ovf_cnt
  );
endinterface

// File: rtl/req_pending_latch.sv
// Request capture for the 16-input priority encoder: edge-detects requests into sticky
// pending bits retired by ack_idx. Optional input synchroniser enabled by macro REQ_SYNC_EN.
module req_pending_latch #(
  parameter int N_REQ       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  req_pending_if.slave bus
);

  logic [N_REQ-1:0] req_s;
  logic [N_REQ-1:0] req_prev_p1;
  logic [N_REQ-1:0] pending_p1;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] clr;
  logic             lost;
  logic [CNT_W-1:0] ovf_cnt_p1;
  logic             ovf_flag_p1;

  if (SYNC_STAGES < 2) begin : g_bad_cfg
    $error("SYNC_STAGES must be at least 2");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

`ifdef REQ_SYNC_EN
  logic [N_REQ-1:0] sync_p0 [SYNC_STAGES];

  // Synchroniser stage: req_in crosses into clk through SYNC_STAGES flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p0[i] <= '0;
    end else if (bus.ena) begin
      sync_p0[0] <= bus.req_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p0[i] <= sync_p0[i-1];
    end
  end

  assign req_s = sync_p0[SYNC_STAGES-1];
`else
  assign req_s = bus.req_in;
`endif

  // Out-of-range indices shift the one-hot past the top bit, so they clear nothing
  always_comb begin
    clr = '0;
    if (bus.ack_valid) clr = {{(N_REQ-1){1'b0}}, 1'b1} << bus.ack_idx;
  end

  assign rise = req_s & ~req_prev_p1;
  assign lost = |(rise & pending_p1 & ~clr);

  // Capture stage: edge history, sticky pending bits and overflow tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_prev_p1 <= '0;
      pending_p1  <= '0;
      ovf_cnt_p1  <= '0;
      ovf_flag_p1 <= 1'b0;
    end else if (bus.ena) begin
      req_prev_p1 <= req_s;
      pending_p1  <= (pending_p1 & ~clr) | rise;
      if (bus.ovf_clr) begin
        ovf_cnt_p1  <= lost ? CNT_W'(1) : '0;
        ovf_flag_p1 <= lost;
      end else if (lost) begin
        ovf_cnt_p1  <= sat_inc(ovf_cnt_p1);
        ovf_flag_p1 <= 1'b1;
      end
    end
  end

  assign bus.pending_out = pending_p1 & ~bus.mask;
  assign bus.any_pending = |bus.pending_out;
  assign bus.ovf_cnt     = ovf_cnt_p1;
  assign bus.ovf_flag    = ovf_flag_p1;

endmodule

// File: tb/tb_req_pending_latch.sv
// Directed bench for req_pending_latch; request-to-pending latency follows REQ_SYNC_EN.
module tb_req_pending_latch;

`ifdef REQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  req_pending_if #(.N_REQ(16), .CNT_W(8)) bus ();

  req_pending_latch #(.N_REQ(16), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ack(input int idx);
    bus.ack_valid = 1'b1;
    bus.ack_idx   = 4'(idx);
    step(1);
    bus.ack_valid = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst_n         = 1'b0;
    bus.ena       = 1'b1;
    bus.req_in    = '0;
    bus.mask      = '0;
    bus.ack_valid = 1'b0;
    bus.ack_idx   = '0;
    bus.ovf_clr   = 1'b0;
    step(3);
    check("rst_pending", 32'(bus.pending_out), 32'h0);
    check("rst_any",     32'(bus.any_pending), 32'h0);
    check("rst_cnt",     32'(bus.ovf_cnt),     32'h0);
    check("rst_flag",    32'(bus.ovf_flag),    32'h0);
    rst_n = 1'b1;
    step(2);

    // first request and its latency
    bus.req_in = 16'h0001;
    step(LAT - 1);
    check("lat_early", 32'(bus.pending_out), 32'h0);
    step(1);
    check("lat_pending", 32'(bus.pending_out), 32'h0001);
    check("lat_any",     32'(bus.any_pending), 32'h1);

    // reset mid-stream clears outputs at once
    rst_n = 1'b0;
    #1;
    check("midrst_pending", 32'(bus.pending_out), 32'h0);
    check("midrst_any",     32'(bus.any_pending), 32'h0);
    bus.req_in = '0;
    step(2);
    rst_n = 1'b1;
    step(LAT + 1);
    check("post_rst_idle", 32'(bus.pending_out), 32'h0);

    // two bits together, ack one, re-ack is a no-op
    bus.req_in = 16'h1008;
    step(LAT);
    bus.req_in = '0;
    check("pair_set", 32'(bus.pending_out), 32'h1008);
    ack(12);
    check("ack12", 32'(bus.pending_out), 32'h0008);
    ack(12);
    check("ack12_again", 32'(bus.pending_out), 32'h0008);
    ack(3);
    check("ack3_pending", 32'(bus.pending_out), 32'h0);
    check("ack3_any",     32'(bus.any_pending), 32'h0);
    step(LAT);

    // re-assertion while pending is a lost event
    bus.req_in = 16'h0020;
    step(LAT);
    check("bit5_set", 32'(bus.pending_out), 32'h0020);
    bus.req_in = '0;
    step(LAT + 1);
    bus.req_in = 16'h0020;
    step(LAT);
    check("ovf1_cnt",     32'(bus.ovf_cnt),     32'h1);
    check("ovf1_flag",    32'(bus.ovf_flag),    32'h1);
    check("ovf1_pending", 32'(bus.pending_out), 32'h0020);
    bus.req_in = '0;
    step(LAT + 1);
    ack(5);
    check("ack5", 32'(bus.pending_out), 32'h0);

    // set wins over a coincident ack
    bus.req_in = 16'h0080;
    step(LAT);
    bus.req_in = '0;
    step(LAT + 1);
    bus.req_in = 16'h0080;
    step(LAT - 1);
    ack(7);
    check("setwin_pending", 32'(bus.pending_out), 32'h0080);
    check("setwin_cnt",     32'(bus.ovf_cnt),     32'h1);
    bus.req_in = '0;
    step(LAT + 1);
    ack(7);
    check("ack7", 32'(bus.pending_out), 32'h0);

    // output mask
    bus.req_in = 16'h0101;
    step(LAT);
    bus.req_in = '0;
    bus.mask = 16'h00FF;
    #1;
    check("mask_lo",  32'(bus.pending_out), 32'h0100);
    check("mask_any", 32'(bus.any_pending), 32'h1);
    bus.mask = 16'h0000;
    #1;
    check("mask_none", 32'(bus.pending_out), 32'h0101);
    bus.mask = 16'h0101;
    #1;
    check("mask_all_pending", 32'(bus.pending_out), 32'h0);
    check("mask_all_any",     32'(bus.any_pending), 32'h0);
    bus.mask = 16'h0000;
    step(LAT + 1);

    // saturation of the lost-event counter on pending bit 8
    for (int i = 0; i < 300; i++) begin
      bus.req_in = 16'h0100;
      step(1);
      bus.req_in = '0;
      step(1);
    end
    step(LAT + 1);
    check("sat_cnt",  32'(bus.ovf_cnt),  32'hFF);
    check("sat_flag", 32'(bus.ovf_flag), 32'h1);

    // clear coincident with a lost event, then clear alone
    bus.req_in = 16'h0100;
    step(LAT - 1);
    bus.ovf_clr = 1'b1;
    step(1);
    bus.ovf_clr = 1'b0;
    check("clr_lost_cnt",  32'(bus.ovf_cnt),  32'h1);
    check("clr_lost_flag", 32'(bus.ovf_flag), 32'h1);
    bus.req_in = '0;
    step(LAT + 1);
    bus.ovf_clr = 1'b1;
    step(1);
    bus.ovf_clr = 1'b0;
    check("clr_cnt",  32'(bus.ovf_cnt),  32'h0);
    check("clr_flag", 32'(bus.ovf_flag), 32'h0);

    // ena low freezes everything; a pulse inside the window is lost
    bus.ena = 1'b0;
    ack(0);
    bus.req_in = 16'h8000;
    step(2);
    bus.req_in = '0;
    step(1);
    check("hold_pending", 32'(bus.pending_out), 32'h0101);
    bus.ena = 1'b1;
    step(LAT + 1);
    check("hold_lost_pulse", 32'(bus.pending_out), 32'h0101);
    ack(0);
    check("ack0", 32'(bus.pending_out), 32'h0100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
